// File: rtl/periph_rx_fifo.sv
// Producer-side four-phase send/ack receiver feeding a DEPTH-entry show-ahead FIFO.
// Define PERIPH_RX_DROP_EN to discard words on a full FIFO (sticky o_ovf) instead of stalling.
module periph_rx_fifo #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_send,
  input  logic [DATA_W-1:0]          i_new_data,
  output logic                       o_ack,
  input  logic                       i_rd_en,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_ovf,
  input  logic                       i_ovf_clr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  typedef enum logic [1:0] {StIdle, StAck, StStall} state_e;

  state_e            r_state;
  logic              r_ack;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_pop;

  assign w_full  = (r_count == CntFull);
  assign w_empty = (r_count == '0);
  // A write happens only on the IDLE/STALL -> ACK transition, so exactly once per handshake.
  assign w_wr    = i_send & ~w_full & (r_state != StAck);
  assign w_pop   = i_rd_en & ~w_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_ack   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_send) begin
            if (!w_full) begin
              r_state <= StAck;
              r_ack   <= 1'b1;
            end else begin
`ifdef PERIPH_RX_DROP_EN
              r_state <= StAck;
              r_ack   <= 1'b1;
`else
              r_state <= StStall;
              r_ack   <= 1'b0;
`endif
            end
          end
        end
        StStall: begin
          if (!i_send) begin
            r_state <= StIdle;
            r_ack   <= 1'b0;
          end else if (!w_full) begin
            r_state <= StAck;
            r_ack   <= 1'b1;
          end
        end
        StAck: begin
          if (!i_send) begin
            r_state <= StIdle;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_new_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef PERIPH_RX_DROP_EN
  logic w_drop;
  logic r_ovf;

  assign w_drop = i_send & w_full & (r_state == StIdle);

  // Set wins over a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (i_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_ovf = r_ovf;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = i_ovf_clr;
  assign o_ovf            = 1'b0;
`endif

  assign o_ack     = r_ack;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_count   = r_count;

endmodule

// File: tb/tb_periph_rx_fifo.sv
// Scoreboard bench for periph_rx_fifo: accepted words are queued, pops are checked in order.
module tb_periph_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       send;
  logic [3:0] new_data;
  logic       ack;
  logic       rd_en;
  logic [3:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       ovf;
  logic       ovf_clr;

  int n_cmp;
  int n_err;
  logic [3:0] sb_q[$];

  periph_rx_fifo #(
    .DATA_W(4),
    .DEPTH (4)
  ) u_dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_send    (send),
    .i_new_data(new_data),
    .o_ack     (ack),
    .i_rd_en   (rd_en),
    .o_rd_data (rd_data),
    .o_empty   (empty),
    .o_full    (full),
    .o_count   (count),
    .o_ovf     (ovf),
    .i_ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full four-phase handshake; the word is queued as expected output.
  task automatic handshake(input logic [3:0] d);
    bit seen;
    seen     = 1'b0;
    send     = 1'b1;
    new_data = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ack;
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
    sb_q.push_back(d);
    send = 1'b0;
    @(negedge clk);
    check("ack_drop", ack, 1'b0);
  endtask

  task automatic pop();
    logic [3:0] exp;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check("rd_data", rd_data, exp);
      check("not_empty", empty, 1'b0);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    send     = 1'b0;
    new_data = '0;
    rd_en    = 1'b0;
    ovf_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single handshake with explicit ack timing.
    send     = 1'b1;
    new_data = 4'hA;
    @(negedge clk);
    check("a_ack_rise", ack, 1'b1);
    check("a_count", count, 3'd1);
    check("a_empty", empty, 1'b0);
    check("a_rd_data", rd_data, 4'hA);
    sb_q.push_back(4'hA);
    send = 1'b0;
    @(negedge clk);
    check("a_ack_fall", ack, 1'b0);
    pop();
    check("a_empty_after", empty, 1'b1);

    // Fill, then drain in order.
    for (int i = 1; i <= 4; i++) handshake(4'(i));
    check("fill_full", full, 1'b1);
    check("fill_count", count, 3'd4);
    for (int i = 0; i < 4; i++) pop();
    check("drain_empty", empty, 1'b1);
    check("drain_count", count, 3'd0);

    // Full FIFO plus one more send.
    for (int i = 1; i <= 4; i++) handshake(4'(i));
    send     = 1'b1;
    new_data = 4'h5;
    @(negedge clk);
`ifdef PERIPH_RX_DROP_EN
    check("drop_ack", ack, 1'b1);
    check("drop_count", count, 3'd4);
    check("drop_ovf", ovf, 1'b1);
    send = 1'b0;
    @(negedge clk);
    check("drop_ovf_hold", ovf, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("drop_ovf_clr", ovf, 1'b0);
    for (int i = 0; i < 4; i++) pop();
`else
    repeat (2) @(negedge clk);
    check("stall_ack", ack, 1'b0);
    check("stall_count", count, 3'd4);
    pop();
    check("stall_ack_pop", ack, 1'b0);
    check("stall_count_pop", count, 3'd3);
    @(negedge clk);
    check("stall_ack_rise", ack, 1'b1);
    check("stall_count_refill", count, 3'd4);
    sb_q.push_back(4'h5);
    send = 1'b0;
    @(negedge clk);
    check("stall_ack_fall", ack, 1'b0);
    check("stall_ovf", ovf, 1'b0);
    for (int i = 0; i < 4; i++) pop();
`endif
    check("cfg_empty", empty, 1'b1);

    // Simultaneous write and pop at count 2.
    handshake(4'h6);
    handshake(4'h7);
    send     = 1'b1;
    new_data = 4'h8;
    check("sim_rd_data", rd_data, sb_q.pop_front());
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("sim_ack", ack, 1'b1);
    check("sim_count", count, 3'd2);
    sb_q.push_back(4'h8);
    send = 1'b0;
    @(negedge clk);
    pop();
    pop();
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    rd_en = 1'b0;
    check("under_count", count, 3'd0);
    check("under_empty", empty, 1'b1);
    handshake(4'h9);
    check("under_count1", count, 3'd1);
    pop();

    // Asynchronous reset while in ACK with three words stored.
    handshake(4'hB);
    handshake(4'hC);
    send     = 1'b1;
    new_data = 4'hD;
    @(negedge clk);
    check("rst_pre_ack", ack, 1'b1);
    check("rst_pre_count", count, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ack", ack, 1'b0);
    check("arst_count", count, 3'd0);
    check("arst_full", full, 1'b0);
    check("arst_empty", empty, 1'b1);
    sb_q.delete();
    send = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    handshake(4'h3);
    pop();
    check("post_rst_empty", empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/periph_rx_fifo.md
# periph_rx_fifo

Parametrised successor to the single-word peripheral receiver: accepts words from a producer over a four-phase `send`/`ack` handshake and buffers them in a DEPTH-entry FIFO. The CPU drains the FIFO through a show-ahead read port. Sits between the producer-side handshake and the CPU bus interface. When the FIFO is full it applies back-pressure by withholding `ack`.

## Interface
- `DATA_W`, 4: word width in bits, ≥1.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `send` in 1: producer request; held high with `newData` stable until `ack` is seen.
- `newData` in DATA_W: producer word.
- `ack` out 1: registered acknowledge.
- `rd_en` in 1: CPU pop request.
- `rd_data` out DATA_W: head word; valid when `empty`=0.
- `empty` out 1: FIFO holds no words.
- `full` out 1: FIFO holds DEPTH words.
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `ovf` out 1: sticky drop flag; see Configuration.
- `ovf_clr` in 1: synchronous clear of `ovf`.

## Operation
- FSM states:
  - IDLE: `ack`=0.
  - ACK: `ack`=1.
  - STALL: `ack`=0; producer waiting on a full FIFO.
- IDLE, `send`=1, `full`=0: write `newData` at the write pointer, advance it, go to ACK.
- IDLE, `send`=1, `full`=1: go to STALL; nothing is written.
- IDLE, `send`=0: stay in IDLE.
- STALL: stay while `full`=1. When `full`=0 and `send`=1, write and go to ACK. When `send`=0 (producer abort), go to IDLE.
- ACK: stay while `send`=1. When `send`=0, go to IDLE. Exactly one write per handshake.
- `full` is the registered value at the start of the cycle. A pop in the same cycle does not unblock a write until the next cycle.
- Pop: `rd_en`=1 and `empty`=0 advances the read pointer. `rd_en` while empty is ignored; pointers and `count` are unchanged.
- Simultaneous write and pop: both pointers advance and `count` is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `count` increments on a write, decrements on a pop, and is otherwise held.
- `empty` = (`count`==0). `full` = (`count`==DEPTH).
- `rd_data` = mem[read pointer], combinational from storage. Contents are undefined when `empty`=1. Storage is not reset.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `ack`=0, pointers=0, `count`=0, `empty`=1, `full`=0, `ovf`=0, `rd_data` don't-care.
- Reset mid-handshake drops any pending transfer and deasserts `ack` immediately.
- `send` sampled high at edge N, with space available: word written at edge N; `ack`=1 from edge N until the edge after `send` is sampled low.
- Write-to-read latency is 1 cycle: `empty` falls and `rd_data` is valid after edge N.
- Pop at edge M: the next word appears on `rd_data` after edge M.
- Minimum handshake period is 2 cycles (IDLE→ACK→IDLE). Throughput is 1 word per 2 cycles.
- STALL→ACK occurs at the first edge where `full` is registered 0, i.e. one cycle after the freeing pop.

## Configuration
- `PERIPH_RX_DROP_EN` defined:
  - IDLE with `send`=1 and `full`=1 goes directly to ACK; the word is discarded and `ovf` is set to 1.
  - STALL is never entered.
  - `ovf` holds until `ovf_clr`=1. If a set and a clear occur in the same cycle, set wins.
- `PERIPH_RX_DROP_EN` undefined: back-pressure behaviour as described in Operation. `ovf` is tied to 0 and `ovf_clr` is ignored.

## Test plan
- Reset, then one handshake with `newData`=4'hA: `ack` rises the cycle after `send`. After `send` drops, `ack` falls one cycle later. `rd_data`=4'hA, `count`=1, `empty`=0.
- Four handshakes 1,2,3,4 (DEPTH=4), then four pops: `full`=1 after the 4th write; reads return 1,2,3,4 in order; `empty`=1 at the end; pointers have wrapped to 0.
- Full FIFO, then `send` with 4'h5, drop macro off: `ack` held 0 (STALL). One pop follows; `ack` rises one cycle later, `count` returns to 4, and the tail word is 5.
- Full FIFO, then `send` with 4'h5, drop macro on: `ack` rises without stall, `count` stays 4, `ovf`=1. `ovf_clr` pulse clears `ovf`; subsequent reads return 1,2,3,4.
- Pop and write in the same cycle with `count`=2: `count` stays 2 and the order is preserved. `rd_en` on empty FIFO: `count` stays 0 and there is no underflow.
- Assert `rst`=0 asynchronously while in ACK with `count`=3: `ack`, `count`, `full` go to 0 and `empty` goes to 1 before the next edge.
